qif_synapse_driver: RTL and testbench
=====================================

Name: qif_synapse_driver

Overview:
- Event-driven synaptic current source that generates the 8-bit signed synaptic current consumed by a QIF neuron's I_syn input.
- Accepts presynaptic spike events over a valid/ready handshake and buffers them in a small FIFO.
- Each event is weighted from a programmable weight register file and accumulated, with saturation, into the current.
- On every time-step tick the current decays exponentially toward zero.

Parameters:
- N_INPUTS, 4, number of presynaptic sources (one weight each).
- IDX_W, 2, width of spike source index (clog2 of N_INPUTS).
- FIFO_DEPTH, 4, spike event buffer depth (power of two).
- DECAY_SHIFT, 2, decay per tick: I minus (I arithmetic-shifted right by DECAY_SHIFT).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-high.
- tick  input  1  time-step strobe; one decay per cycle it is high.
- spike_valid  input  1  presynaptic spike event present.
- spike_idx  input  IDX_W  source index of the event.
- spike_ready  output  1  event accepted when valid and ready are both high on a clk edge.
- w_we  input  1  weight write enable.
- w_addr  input  IDX_W  weight index.
- w_data  input  8  signed weight.
- i_syn  output  8  signed synaptic current, registered.
- fifo_level  output  clog2(FIFO_DEPTH)+1  occupied entries, registered.

Behaviour:
- Reset (async, rst_n high): i_syn=0, FIFO empty, fifo_level=0, all weights=0. spike_ready=0 while reset is asserted.
- spike_ready = (fifo_level < FIFO_DEPTH), combinational from registered state.
  - Push and pop in the same cycle on a full FIFO is not allowed; ready stays low.
- Each cycle, exactly one of the following occurs:
  - DECAY (tick=1): i_syn <= i_syn - (i_syn >>> DECAY_SHIFT).
    - If i_syn > 0 and (i_syn >>> DECAY_SHIFT) == 0, i_syn <= i_syn - 1, so positive values reach 0.
    - Negative values reach 0 naturally (-1 >>> S = -1).
    - No FIFO pop in a tick cycle; ticks have priority over events.
  - ACCUM (tick=0, FIFO non-empty): pop the head entry and set i_syn <= sat8(i_syn + weight[head_idx]).
    - Computed in 9-bit signed, then clamped to the range -128..127.
  - HOLD: otherwise i_syn is unchanged.
- Latency:
  - An event accepted at edge k into an empty FIFO pops at edge k+1, so i_syn reflects it after edge k+1 if tick=0 that cycle.
  - Back-to-back events are accumulated at one per cycle.
- Push and pop in the same cycle: level unchanged; pointers wrap modulo FIFO_DEPTH.
- Weight write colliding with a pop of the same index: the pop uses the old weight; the new weight takes effect next cycle.
- Events are processed strictly in arrival order.
- Control FSM states:
  - EMPTY: level=0.
  - ACTIVE: 0<level<FIFO_DEPTH.
  - FULL: level=FIFO_DEPTH, spike_ready=0.
  - Transitions follow push/pop per cycle. Reset mid-operation discards buffered events.

Decomposition:
- Shared package holds:
  - the I_syn width constant (8);
  - the saturation limits (127, -128);
  - a signed 8-bit weight/current typedef, shared with the neuron's I_syn port.
- One sub-module: syn_event_fifo, a parameterised synchronous FIFO with push/pop, level, and full/empty flags.
- Weight register file, decay and saturation logic stay in the top level.

Test Plan:
- Reset, write w0=10, tick=0, one spike idx0 -> i_syn=10 one cycle after acceptance; fifo_level returns to 0.
- w1=100, two back-to-back spikes idx1 -> i_syn 100 then 127 (saturated, not wrapping to -56).
- w2=-50, three spikes idx2 from i_syn=0 -> -50, -100, -128 (clamped).
- From i_syn=40, DECAY_SHIFT=2, tick held high 4 cycles -> 30, 23, 18, 14. From i_syn=1, one tick -> 0. From -1, one tick -> 0.
- Hold tick high, offer 6 spikes idx0 (w0=5) -> 4 accepted, spike_ready low at level 4; drop tick -> i_syn climbs 5,10,15,20 over 4 cycles; ready reasserts after first pop.
- Mid-operation async reset with FIFO level 3 and i_syn=60 -> immediately i_syn=0, level=0, weights 0; post-reset spike idx0 -> i_syn stays 0.

Source files
------------

// File: rtl/qif_synapse_driver_pkg.sv
// Shared types and limits for the QIF synaptic current path.
// The current type is shared with the neuron's I_syn input.
package qif_synapse_driver_pkg;

    localparam int ISYN_W = 8;

    typedef logic signed [ISYN_W-1:0] syn_val_t;

    localparam logic signed [ISYN_W:0] SAT_MAX = 9'sd127;
    localparam logic signed [ISYN_W:0] SAT_MIN = -9'sd128;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ACTIVE,
        ST_FULL
    } fifo_state_t;

    // Clamp a one-bit-wider signed sum back into the current range
    function automatic syn_val_t sat8(input logic signed [ISYN_W:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[ISYN_W-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[ISYN_W-1:0];
        end
        return v[ISYN_W-1:0];
    endfunction

endpackage

// File: rtl/qif_synapse_driver_fifo.sv
// Small synchronous event FIFO; the EMPTY/ACTIVE/FULL control state
// directly provides the registered empty and full flags.
module syn_event_fifo
    import qif_synapse_driver_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    fifo_state_t      state;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full      = (state == ST_FULL);
    assign empty     = (state == ST_EMPTY);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state  <= ST_EMPTY;
            level  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case (state)
                ST_EMPTY: begin
                    if (do_push) begin
                        level <= LVL_W'(1);
                        state <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (do_push && !do_pop) begin
                        level <= level + LVL_W'(1);
                        if (level == LVL_W'(DEPTH - 1)) begin
                            state <= ST_FULL;
                        end
                    end else if (do_pop && !do_push) begin
                        level <= level - LVL_W'(1);
                        if (level == LVL_W'(1)) begin
                            state <= ST_EMPTY;
                        end
                    end
                end
                ST_FULL: begin
                    if (do_pop) begin
                        level <= level - LVL_W'(1);
                        state <= ST_ACTIVE;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/qif_synapse_driver.sv
// Event-driven synaptic current source: buffered spike events are weighted
// and accumulated with saturation; each tick decays the current toward zero.
module qif_synapse_driver
    import qif_synapse_driver_pkg::*;
#(
    parameter int N_INPUTS    = 4,
    parameter int IDX_W       = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int DECAY_SHIFT = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        tick,
    input  logic                        spike_valid,
    input  logic [IDX_W-1:0]            spike_idx,
    output logic                        spike_ready,
    input  logic                        w_we,
    input  logic [IDX_W-1:0]            w_addr,
    input  syn_val_t                    w_data,
    output syn_val_t                    i_syn,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    syn_val_t                weight [N_INPUTS];
    logic [IDX_W-1:0]        head_idx;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    push;
    logic                    pop;
    syn_val_t                head_weight;
    syn_val_t                decay_amt;
    syn_val_t                i_syn_next;
    logic signed [ISYN_W:0]  acc_sum;

    // Ticks take priority, so the FIFO only drains in non-tick cycles
    assign spike_ready = !rst_n && !fifo_full;
    assign push        = spike_valid && spike_ready;
    assign pop         = !tick && !fifo_empty;

    syn_event_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (spike_idx),
        .pop       (pop),
        .head_data (head_idx),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // A write racing a pop of the same index is seen only from the next cycle
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                weight[i] <= '0;
            end
        end else if (w_we) begin
            weight[w_addr] <= w_data;
        end
    end

    // Small positive values would stall under a pure shift, so force a -1 step
    always_comb begin
        head_weight = weight[head_idx];
        decay_amt   = i_syn >>> DECAY_SHIFT;
        acc_sum     = {i_syn[ISYN_W-1], i_syn} + {head_weight[ISYN_W-1], head_weight};
        i_syn_next  = i_syn;
        if (tick) begin
            if (!i_syn[ISYN_W-1] && (i_syn != '0) && (decay_amt == '0)) begin
                i_syn_next = i_syn - ISYN_W'(1);
            end else begin
                i_syn_next = i_syn - decay_amt;
            end
        end else if (!fifo_empty) begin
            i_syn_next = sat8(acc_sum);
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            i_syn <= '0;
        end else begin
            i_syn <= i_syn_next;
        end
    end

endmodule

// File: tb/tb_qif_synapse_driver.sv
// Scoreboard bench for qif_synapse_driver: directed vectors queue expected
// state, a monitor pops and compares at fixed points in each cycle.
module tb_qif_synapse_driver;
    import qif_synapse_driver_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       spike_valid;
    logic [1:0] spike_idx;
    logic       spike_ready;
    logic       w_we;
    logic [1:0] w_addr;
    syn_val_t   w_data;
    syn_val_t   i_syn;
    logic [2:0] fifo_level;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int       due;
        int       phase;
        string    name;
        syn_val_t isyn;
        logic [2:0] lvl;
        logic     rdy;
    } exp_t;

    exp_t sb[$];

    qif_synapse_driver #(
        .N_INPUTS    (4),
        .IDX_W       (2),
        .FIFO_DEPTH  (4),
        .DECAY_SHIFT (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .spike_valid (spike_valid),
        .spike_idx   (spike_idx),
        .spike_ready (spike_ready),
        .w_we        (w_we),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .i_syn       (i_syn),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic pushExp(input string name, input int isyn, input int lvl,
                           input logic rdy, input int phase);
        exp_t e;
        e.due   = cyc;
        e.phase = phase;
        e.name  = name;
        e.isyn  = syn_val_t'(isyn);
        e.lvl   = 3'(lvl);
        e.rdy   = rdy;
        sb.push_back(e);
    endtask

    task automatic expectNext(input string name, input int isyn, input int lvl);
        pushExp(name, isyn, lvl, (lvl < 4), 0);
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (i_syn !== e.isyn || fifo_level !== e.lvl || spike_ready !== e.rdy) begin
            errors++;
            $display("[TB] FAIL %s: got i_syn=%0d level=%0d ready=%0b, expected i_syn=%0d level=%0d ready=%0b",
                     e.name, i_syn, fifo_level, spike_ready, e.isyn, e.lvl, e.rdy);
        end
    endtask

    task automatic drain(input int ph);
        exp_t e;
        while (sb.size() > 0 &&
               (sb[0].due < cyc || (sb[0].due == cyc && sb[0].phase <= ph))) begin
            e = sb.pop_front();
            if (e.due == cyc && e.phase == ph) begin
                checkOutput(e);
            end else begin
                checks++;
                errors++;
                $display("[TB] FAIL %s: sample point missed (cycle %0d, due %0d)", e.name, cyc, e.due);
            end
        end
    endtask

    // Phase 0 samples mid-cycle; phase 1 samples just before the next rising edge
    initial begin
        forever begin
            @(negedge clk);
            drain(0);
            #4;
            drain(1);
        end
    end

    task automatic applyStimulus(input logic t, input logic v, input logic [1:0] idx);
        tick        = t;
        spike_valid = v;
        spike_idx   = idx;
        @(posedge clk);
        #1;
    endtask

    task automatic writeWeight(input logic [1:0] addr, input int data);
        tick        = 1'b0;
        spike_valid = 1'b0;
        w_we        = 1'b1;
        w_addr      = addr;
        w_data      = syn_val_t'(data);
        @(posedge clk);
        #1;
        w_we        = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b1;
        tick        = 1'b0;
        spike_valid = 1'b0;
        spike_idx   = '0;
        w_we        = 1'b0;
        w_addr      = '0;
        w_data      = '0;

        @(posedge clk);
        #1;
        pushExp("reset state", 0, 0, 1'b0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        pushExp("idle after reset", 0, 0, 1'b1, 0);

        // single event, one-cycle latency
        writeWeight(2'd0, 10);          expectNext("w0 write", 0, 0);
        applyStimulus(0, 1, 2'd0);      expectNext("spike0 accepted", 0, 1);
        applyStimulus(0, 0, 2'd0);      expectNext("spike0 accumulated", 10, 0);
        writeWeight(2'd3, -10);         expectNext("w3 write", 10, 0);
        applyStimulus(0, 1, 2'd3);      expectNext("spike3 accepted", 10, 1);

        // positive saturation
        writeWeight(2'd1, 100);         expectNext("cancel to zero", 0, 0);
        applyStimulus(0, 1, 2'd1);      expectNext("spike1 a", 0, 1);
        applyStimulus(0, 1, 2'd1);      expectNext("spike1 b", 100, 1);
        applyStimulus(0, 0, 2'd0);      expectNext("positive clamp", 127, 0);

        // negative saturation
        writeWeight(2'd3, -127);        expectNext("w3 write -127", 127, 0);
        applyStimulus(0, 1, 2'd3);      expectNext("spike3 b", 127, 1);
        writeWeight(2'd2, -50);         expectNext("back to zero", 0, 0);
        applyStimulus(0, 1, 2'd2);      expectNext("spike2 a", 0, 1);
        applyStimulus(0, 1, 2'd2);      expectNext("spike2 b", -50, 1);
        applyStimulus(0, 1, 2'd2);      expectNext("spike2 c", -100, 1);
        applyStimulus(0, 0, 2'd0);      expectNext("negative clamp", -128, 0);

        // decay of negative and positive values
        writeWeight(2'd3, 127);         expectNext("w3 write 127", -128, 0);
        applyStimulus(0, 1, 2'd3);      expectNext("spike3 c", -128, 1);
        applyStimulus(0, 0, 2'd0);      expectNext("reach -1", -1, 0);
        applyStimulus(1, 0, 2'd0);      expectNext("decay -1", 0, 0);
        writeWeight(2'd3, 40);          expectNext("w3 write 40", 0, 0);
        applyStimulus(0, 1, 2'd3);      expectNext("spike3 d", 0, 1);
        applyStimulus(0, 0, 2'd0);      expectNext("reach 40", 40, 0);
        applyStimulus(1, 0, 2'd0);      expectNext("decay 1", 30, 0);
        applyStimulus(1, 0, 2'd0);      expectNext("decay 2", 23, 0);
        applyStimulus(1, 0, 2'd0);      expectNext("decay 3", 18, 0);
        applyStimulus(1, 0, 2'd0);      expectNext("decay 4", 14, 0);

        // weight write colliding with a pop of the same index
        writeWeight(2'd3, -13);         expectNext("w3 write -13", 14, 0);
        applyStimulus(0, 1, 2'd3);      expectNext("spike3 e", 14, 1);
        writeWeight(2'd3, 99);          expectNext("collision old weight", 1, 0);
        applyStimulus(1, 0, 2'd0);      expectNext("decay +1", 0, 0);
        applyStimulus(0, 1, 2'd3);      expectNext("spike3 f", 0, 1);
        writeWeight(2'd3, -99);         expectNext("new weight applied", 99, 0);
        applyStimulus(0, 1, 2'd3);      expectNext("spike3 g", 99, 1);
        applyStimulus(0, 0, 2'd0);      expectNext("cancel 99", 0, 0);

        // backpressure while ticks block the drain
        writeWeight(2'd0, 5);           expectNext("w0 write 5", 0, 0);
        applyStimulus(1, 1, 2'd0);      expectNext("fill 1", 0, 1);
        applyStimulus(1, 1, 2'd0);      expectNext("fill 2", 0, 2);
        applyStimulus(1, 1, 2'd0);      expectNext("fill 3", 0, 3);
        applyStimulus(1, 1, 2'd0);      expectNext("fill 4 full", 0, 4);
        applyStimulus(1, 1, 2'd0);      expectNext("full reject 1", 0, 4);
        applyStimulus(1, 1, 2'd0);      expectNext("full reject 2", 0, 4);
        applyStimulus(0, 0, 2'd0);      expectNext("drain 1", 5, 3);
        applyStimulus(0, 0, 2'd0);      expectNext("drain 2", 10, 2);
        applyStimulus(0, 0, 2'd0);      expectNext("drain 3", 15, 1);
        applyStimulus(0, 0, 2'd0);      expectNext("drain 4", 20, 0);

        // mid-operation asynchronous reset
        writeWeight(2'd1, 51);          expectNext("w1 write 51", 20, 0);
        applyStimulus(1, 1, 2'd1);      expectNext("preload 1", 15, 1);
        applyStimulus(1, 1, 2'd0);      expectNext("preload 2", 12, 2);
        applyStimulus(1, 1, 2'd0);      expectNext("preload 3", 9, 3);
        applyStimulus(0, 1, 2'd0);      expectNext("pre-reset state", 60, 3);
        @(negedge clk);
        #1;
        rst_n       = 1'b1;
        tick        = 1'b0;
        spike_valid = 1'b0;
        pushExp("async reset", 0, 0, 1'b0, 1);
        @(posedge clk);
        #1;
        pushExp("reset held", 0, 0, 1'b0, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        applyStimulus(0, 1, 2'd0);      expectNext("post-reset spike0", 0, 1);
        applyStimulus(0, 1, 2'd1);      expectNext("post-reset w0 zero", 0, 1);
        applyStimulus(0, 0, 2'd0);      expectNext("post-reset w1 zero", 0, 0);

        for (int k = 0; k < 20 && sb.size() > 0; k++) begin
            @(posedge clk);
        end
        if (sb.size() > 0) begin
            $display("[TB] FAIL scoreboard drain: %0d expectations left, required 0", sb.size());
            checks += sb.size();
            errors += sb.size();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
